handshake_rr_arbiter: RTL and testbench

HANDSHAKE_RR_ARBITER -- requirements
Module: handshake_rr_arbiter

---
 rtl/arb_pkg.sv | 29 ++
 rtl/arb_out_slice.sv | 65 ++++++
 rtl/handshake_rr_arbiter.sv | 138 +++++++++++++
 tb/tb_handshake_rr_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants and the rotating-priority pick used by the round-robin arbiter.
package arb_pkg;

    localparam int BURST_CNT_W = 8;
    localparam int MAX_REQ     = 16;

    // One-hot of the first set bit of vld, scanning upward from ptr and wrapping at n.
    function automatic logic [MAX_REQ-1:0] rr_pick_onehot(
        input logic [MAX_REQ-1:0] vld,
        input logic [3:0]         ptr,
        input int                 n
    );
        logic [MAX_REQ-1:0] oh;
        logic               found;
        int                 idx;
        oh    = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= n) idx = idx - n;
            if (i < n && !found && vld[idx[3:0]]) begin
                oh[idx[3:0]] = 1'b1;
                found        = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/arb_out_slice.sv
// Two-entry skid register slice: registered outputs, registered upstream ready, 1 beat/cycle.
module arb_out_slice
    import arb_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         in_ready_o,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    input  logic         out_ready_i
);

    logic         out_vld_q, out_vld_d;
    logic         skid_vld_q, skid_vld_d;
    logic [W-1:0] out_q, out_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_fire;

    assign in_ready_o  = ~skid_vld_q;
    assign in_fire     = in_valid_i & ~skid_vld_q;
    assign out_valid_o = out_vld_q;
    assign out_data_o  = out_q;

    // out_q keeps its last payload when empty so the id output holds its last value.
    always_comb begin
        out_vld_d  = out_vld_q;
        out_d      = out_q;
        skid_vld_d = skid_vld_q;
        skid_d     = skid_q;
        if (!out_vld_q || out_ready_i) begin
            if (skid_vld_q) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = 1'b0;
            end else if (in_fire) begin
                out_d     = in_data_i;
                out_vld_d = 1'b1;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_d     = in_data_i;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
        end
    end

endmodule

// File: rtl/handshake_rr_arbiter.sv
// Round-robin valid/ready arbiter with burst limit and stall lock.
// Define ARB_OUT_REG_EN to register the merged output through arb_out_slice.
module handshake_rr_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          master_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   master_data,
    output logic [NUM_REQ-1:0]          master_ready,
    output logic                        slave_valid,
    output logic [DATA_W-1:0]           slave_data,
    output logic [$clog2(NUM_REQ)-1:0]  slave_id,
    input  logic                        slave_ready
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]        holder_q, holder_d;
    logic [ID_W-1:0]        lock_id_q, lock_id_d;
    logic                   lock_q, lock_d;
    logic [BURST_CNT_W-1:0] cnt_q, cnt_d;
    logic [BURST_CNT_W-1:0] base_cnt;

    logic [MAX_REQ-1:0]     pick_oh;
    logic [ID_W-1:0]        pick_id;
    logic                   gnt_vld;
    logic [ID_W-1:0]        gnt_id;
    logic [DATA_W-1:0]      gnt_data;
    logic                   up_ready;
    logic                   fire;

    assign pick_oh = rr_pick_onehot(MAX_REQ'(master_valid), 4'(rr_ptr_q), NUM_REQ);

    always_comb begin
        pick_id = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (pick_oh[i]) pick_id = ID_W'(i);
        end
    end

    // A stalled beat pins the grant; if its owner drops valid the cycle is empty and lock releases.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = lock_id_q;
        if (lock_q) begin
            gnt_vld = master_valid[lock_id_q];
        end else begin
            gnt_vld = |master_valid;
            gnt_id  = pick_id;
        end
    end

    assign gnt_data = master_data[int'(gnt_id)*DATA_W +: DATA_W];
    assign fire     = gnt_vld & up_ready;

    always_comb begin
        master_ready = '0;
        if (gnt_vld && !rst) master_ready[gnt_id] = up_ready;
    end

    // While under the burst limit rr_ptr parks on the holder, so it keeps winning only while valid.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        holder_d  = holder_q;
        cnt_d     = cnt_q;
        lock_d    = gnt_vld & ~up_ready;
        lock_id_d = gnt_id;
        base_cnt  = (gnt_id == holder_q) ? cnt_q : '0;
        if (fire) begin
            holder_d = gnt_id;
            if (int'(base_cnt) + 1 < MAX_BURST) begin
                cnt_d    = base_cnt + 1'b1;
                rr_ptr_d = gnt_id;
            end else begin
                cnt_d    = '0;
                rr_ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            holder_q  <= '0;
            cnt_q     <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            holder_q  <= holder_d;
            cnt_q     <= cnt_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end

`ifdef ARB_OUT_REG_EN
    logic [ID_W+DATA_W-1:0] slice_out;

    arb_out_slice #(
        .W (ID_W + DATA_W)
    ) u_out_slice (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (gnt_vld),
        .in_data_i   ({gnt_id, gnt_data}),
        .in_ready_o  (up_ready),
        .out_valid_o (slave_valid),
        .out_data_o  (slice_out),
        .out_ready_i (slave_ready)
    );

    assign slave_id   = slice_out[ID_W+DATA_W-1:DATA_W];
    assign slave_data = slice_out[DATA_W-1:0];
`else
    logic [ID_W-1:0] last_id_q;

    assign up_ready    = slave_ready;
    assign slave_valid = gnt_vld & ~rst;
    assign slave_id    = (gnt_vld && !rst) ? gnt_id : last_id_q;
    assign slave_data  = (gnt_vld && !rst) ? gnt_data : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_id_q <= '0;
        end else if (gnt_vld) begin
            last_id_q <= gnt_id;
        end
    end
`endif

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Bench for handshake_rr_arbiter: vector table, directed corner sequences, randomized scoreboard.
`timescale 1ns/1ps
module tb_handshake_rr_arbiter;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int IDW = 2;
    localparam int MB  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    mvalid = '0;
    logic [N*DW-1:0] mdata  = '0;
    logic            sready = 1'b0;

    logic [N-1:0]    mready4, mready1;
    logic            sv4, sv1;
    logic [DW-1:0]   sd4, sd1;
    logic [IDW-1:0]  sid4, sid1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    handshake_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk (clk), .rst (rst), .master_valid (mvalid), .master_data (mdata),
        .master_ready (mready4), .slave_valid (sv4), .slave_data (sd4),
        .slave_id (sid4), .slave_ready (sready)
    );

    handshake_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(1)) dut1 (
        .clk (clk), .rst (rst), .master_valid (mvalid), .master_data (mdata),
        .master_ready (mready1), .slave_valid (sv1), .slave_data (sd1),
        .slave_id (sid1), .slave_ready (sready)
    );

    function automatic logic [DW-1:0] dword(input int ch);
        return 32'hA000_0000 | DW'(ch);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic load_const_data();
        for (int c = 0; c < N; c++) mdata[c*DW +: DW] = dword(c);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        mvalid = '0;
        sready = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct packed {
        logic       sel1;
        logic       r;
        logic [3:0] v;
        logic       rdy;
        logic       esv;
        logic [1:0] eid;
        logic [3:0] emr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic s, input logic r, input logic [3:0] v, input logic rdy,
                       input logic esv, input logic [1:0] eid);
        vec_t e;
        e.sel1 = s; e.r = r; e.v = v; e.rdy = rdy; e.esv = esv; e.eid = eid;
        e.emr  = (esv && rdy) ? (4'b0001 << eid) : 4'b0000;
        tbl.push_back(e);
    endtask

    // Random-test state: per-channel sequence numbers and a behavioural arbitration model.
    logic [23:0] seq_tx[N];
    int          seq_rx[N];
    logic [N-1:0] acc;
    int m_ptr, m_ten_id, m_ten_beats, m_stall_id;
    bit m_stall;

    initial begin
        int beats, cycles, tx_total, rx_total;
        int ids_b[12];
        load_const_data();

`ifndef ARB_OUT_REG_EN
        // MAX_BURST=1, all valid: strict rotation after reset.
        add(1, 1, 4'hF, 1, 0, 0);
        add(1, 0, 4'h0, 1, 0, 0);
        for (int k = 0; k < 5; k++) add(1, 0, 4'hF, 1, 1, 2'(k % 4));
        // MAX_BURST=4, requesters 0 and 1 continuous: bursts of four.
        ids_b = '{0,0,0,0,1,1,1,1,0,0,0,0};
        add(0, 1, 4'h3, 1, 0, 0);
        for (int k = 0; k < 12; k++) add(0, 0, 4'h3, 1, 1, 2'(ids_b[k]));
        // Requester 2 alone for ten beats, then idle keeps the last id.
        add(0, 1, 4'h4, 1, 0, 0);
        for (int k = 0; k < 10; k++) add(0, 0, 4'h4, 1, 1, 2'd2);
        add(0, 0, 4'h0, 1, 0, 2'd2);

        @(posedge clk); #1;
        foreach (tbl[k]) begin
            rst = tbl[k].r; mvalid = tbl[k].v; sready = tbl[k].rdy;
            @(negedge clk);
            if (tbl[k].sel1) begin
                chk($sformatf("vec%0d_valid", k), 64'(sv1), 64'(tbl[k].esv));
                chk($sformatf("vec%0d_id", k), 64'(sid1), 64'(tbl[k].eid));
                chk($sformatf("vec%0d_mready", k), 64'(mready1), 64'(tbl[k].emr));
                if (tbl[k].esv) chk($sformatf("vec%0d_data", k), 64'(sd1), 64'(dword(int'(tbl[k].eid))));
            end else begin
                chk($sformatf("vec%0d_valid", k), 64'(sv4), 64'(tbl[k].esv));
                chk($sformatf("vec%0d_id", k), 64'(sid4), 64'(tbl[k].eid));
                chk($sformatf("vec%0d_mready", k), 64'(mready4), 64'(tbl[k].emr));
                if (tbl[k].esv) chk($sformatf("vec%0d_data", k), 64'(sd4), 64'(dword(int'(tbl[k].eid))));
            end
            @(posedge clk); #1;
        end

        // id1 stalled while requester 0 (higher priority from ptr 0) raises valid.
        pulse_reset();
        mvalid = 4'b0010; sready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) mvalid = 4'b0011;
            @(negedge clk);
            chk($sformatf("stall_id_c%0d", k), 64'(sid4), 64'd1);
            chk($sformatf("stall_data_c%0d", k), 64'(sd4), 64'(dword(1)));
            chk($sformatf("stall_mready_c%0d", k), 64'(mready4), 64'd0);
            @(posedge clk); #1;
        end
        sready = 1'b1;
        @(negedge clk);
        chk("stall_release_mready", 64'(mready4), 64'b0010);
        chk("stall_release_id", 64'(sid4), 64'd1);
        @(posedge clk); #1;
        mvalid = 4'b0001;
        @(negedge clk);
        chk("after_stall_id", 64'(sid4), 64'd0);
        chk("after_stall_mready", 64'(mready4), 64'b0001);
        @(posedge clk); #1;

        // Holder drops valid while stalled: one empty cycle, then re-arbitration.
        pulse_reset();
        mvalid = 4'b0100; sready = 1'b0;
        @(negedge clk);
        chk("drop_locked_id", 64'(sid4), 64'd2);
        @(posedge clk); #1;
        mvalid = 4'b0010;
        @(negedge clk);
        chk("drop_release_valid", 64'(sv4), 64'd0);
        chk("drop_release_id_hold", 64'(sid4), 64'd2);
        @(posedge clk); #1;
        @(negedge clk);
        chk("drop_rearb_valid", 64'(sv4), 64'd1);
        chk("drop_rearb_id", 64'(sid4), 64'd1);
        @(posedge clk); #1;

        // Reset while id3 is stalled: outputs clear at once, first grant afterwards is id0.
        pulse_reset();
        mvalid = 4'b1000; sready = 1'b0;
        @(negedge clk);
        chk("rst_pre_id", 64'(sid4), 64'd3);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rst_async_valid", 64'(sv4), 64'd0);
        chk("rst_async_id", 64'(sid4), 64'd0);
        chk("rst_async_data", 64'(sd4), 64'd0);
        chk("rst_async_mready", 64'(mready4), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; mvalid = 4'hF; sready = 1'b1;
        @(negedge clk);
        chk("rst_first_grant_id", 64'(sid4), 64'd0);
        chk("rst_first_grant_valid", 64'(sv4), 64'd1);
        @(posedge clk); #1;
`else
        // Registered output: beat accepted in cycle 0 appears on the slave side in cycle 1.
        pulse_reset();
        mvalid = 4'b0001; sready = 1'b1;
        @(negedge clk);
        chk("slice_c0_valid", 64'(sv4), 64'd0);
        chk("slice_c0_mready", 64'(mready4), 64'b0001);
        @(posedge clk); #1;
        mvalid = 4'b0000;
        @(negedge clk);
        chk("slice_c1_valid", 64'(sv4), 64'd1);
        chk("slice_c1_id", 64'(sid4), 64'd0);
        chk("slice_c1_data", 64'(sd4), 64'(dword(0)));
        @(posedge clk); #1;
        @(negedge clk);
        chk("slice_c2_empty", 64'(sv4), 64'd0);
        chk("slice_c2_id_hold", 64'(sid4), 64'd0);
        @(posedge clk); #1;
`endif

        // Randomized traffic: masters hold valid until accepted; payload carries {channel, seq}.
        pulse_reset();
        for (int c = 0; c < N; c++) begin seq_tx[c] = '0; seq_rx[c] = 0; end
        m_ptr = 0; m_ten_id = 0; m_ten_beats = 0; m_stall = 0; m_stall_id = 0;
        acc = '0;
        beats = 0; cycles = 0;
        while (beats < 1000 && cycles < 20000) begin
            for (int c = 0; c < N; c++) begin
                if (acc[c]) begin
                    seq_tx[c] = seq_tx[c] + 1'b1;
                    mvalid[c] = 1'b0;
                end
                if (!mvalid[c] && ($urandom_range(0, 1) == 1)) begin
                    mvalid[c] = 1'b1;
                    mdata[c*DW +: DW] = {8'(c), seq_tx[c]};
                end
            end
            sready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            acc = mvalid & mready4;
            chk("rand_mready_onehot0", 64'($onehot0(mready4)), 64'd1);
`ifndef ARB_OUT_REG_EN
            begin
                bit exp_v;
                int exp_id;
                exp_v = 0; exp_id = 0;
                if (m_stall) begin
                    exp_v = mvalid[m_stall_id]; exp_id = m_stall_id;
                end else begin
                    for (int j = 0; j < N; j++) begin
                        if (!exp_v && mvalid[(m_ptr + j) % N]) begin
                            exp_v = 1; exp_id = (m_ptr + j) % N;
                        end
                    end
                end
                chk("model_valid", 64'(sv4), 64'(exp_v));
                if (exp_v) chk("model_id", 64'(sid4), 64'(exp_id));
                chk("model_mready", 64'(mready4), (exp_v && sready) ? (64'd1 << exp_id) : 64'd0);
                if (exp_v && sready) begin
                    m_ten_beats = (exp_id == m_ten_id) ? m_ten_beats + 1 : 1;
                    m_ten_id    = exp_id;
                    if (m_ten_beats >= MB) begin
                        m_ptr = (exp_id + 1) % N; m_ten_beats = 0;
                    end else begin
                        m_ptr = exp_id;
                    end
                end
                m_stall = exp_v && !sready; m_stall_id = exp_id;
            end
`endif
            if (sv4 && sready) begin
                int ch;
                ch = int'(sd4[31:24]);
                if (ch < N) begin
                    chk("rand_id_matches_data", 64'(sid4), 64'(ch));
                    chk($sformatf("rand_seq_ch%0d", ch), 64'(sd4[23:0]), 64'(seq_rx[ch]));
                    seq_rx[ch] = int'(sd4[23:0]) + 1;
                end else begin
                    chk("rand_channel_tag", 64'(ch), 64'(sid4));
                end
                beats++;
            end
            cycles++;
            @(posedge clk); #1;
        end
        chk("rand_beats_within_budget", 64'(beats >= 1000), 64'd1);

        // Drain: stop new traffic and make sure every accepted beat came out exactly once.
        for (int c = 0; c < N; c++) if (acc[c]) begin seq_tx[c] = seq_tx[c] + 1'b1; end
        mvalid = '0; sready = 1'b1; acc = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (sv4) begin
                int ch;
                ch = int'(sd4[31:24]);
                if (ch < N) begin
                    chk($sformatf("drain_seq_ch%0d", ch), 64'(sd4[23:0]), 64'(seq_rx[ch]));
                    seq_rx[ch] = int'(sd4[23:0]) + 1;
                end
            end
            @(posedge clk); #1;
        end
        tx_total = 0; rx_total = 0;
        for (int c = 0; c < N; c++) begin
            tx_total += int'(seq_tx[c]);
            rx_total += seq_rx[c];
        end
        chk("drain_no_loss", 64'(rx_total), 64'(tx_total));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
